// File: rtl/status_frame_receiver.sv
// Status-frame receiver: hunts a magic number, collects a fixed-length payload,
// verifies CRC16 and motor id, and publishes good frames through a stable output buffer.
module status_frame_receiver #(
  parameter logic [31:0] MAGIC          = 32'h1CEB00DA,
  parameter int unsigned MAGIC_LEN      = 4,
  parameter int unsigned PAYLOAD_LEN    = 22,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic [7:0]               expected_id,
  input  logic                     id_check_en,
  input  logic                     clear_counters,
  output logic                     busy,
  output logic                     frame_valid,
  output logic [7:0]               frame_id,
  output logic [8*PAYLOAD_LEN-1:0] frame_payload,
  output logic                     crc_error,
  output logic                     id_error,
  output logic                     timeout_error,
  output logic [CNT_W-1:0]         good_count,
  output logic [CNT_W-1:0]         crc_error_count,
  output logic [CNT_W-1:0]         timeout_count
);

  localparam int unsigned MAGIC_W = 8 * MAGIC_LEN;
  localparam int unsigned HIST_W  = (MAGIC_LEN > 1) ? 8 * (MAGIC_LEN - 1) : 8;
  localparam int unsigned IDX_W   = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int unsigned TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [MAGIC_W-1:0] MAGIC_V  = MAGIC[MAGIC_W-1:0];
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO, CHECK} state_t;

  state_t                   state;
  logic [HIST_W-1:0]        hist;
  logic [HIST_W-1:0]        hist_next;
  logic                     magic_hit;
  logic [IDX_W-1:0]         idx;
  logic [15:0]              crc;
  logic [15:0]              rx_crc;
  logic [8*PAYLOAD_LEN-1:0] shadow;
  logic [TMR_W-1:0]         timer;
  logic                     in_rx_state;
  logic                     expire;
  logic                     crc_ok;
  logic                     id_ok;
  logic                     check_good;
  logic                     check_crc_bad;
  logic                     check_id_bad;

  // CRC16 poly 0x8005, data MSB first, one byte per call.
  function automatic logic [15:0] crc16_d8(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int unsigned i = 8; i > 0; i--) begin
      if (c[15] ^ d[i-1]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + 1'b1 : c;
  endfunction

  // Only the previous MAGIC_LEN-1 bytes need storing; the newest byte is rx_data itself.
  if (MAGIC_LEN == 1) begin : g_magic1
    assign magic_hit = (rx_data == MAGIC_V);
    assign hist_next = '0;
  end else if (MAGIC_LEN == 2) begin : g_magic2
    assign magic_hit = ({hist, rx_data} == MAGIC_V);
    assign hist_next = rx_data;
  end else begin : g_magicn
    assign magic_hit = ({hist, rx_data} == MAGIC_V);
    assign hist_next = {hist[HIST_W-9:0], rx_data};
  end

  assign busy          = (state != HUNT);
  assign in_rx_state   = (state == PAYLOAD) || (state == CRC_HI) || (state == CRC_LO);
  // Timer holds the cycles left including the current one; expiry is the cycle it would hit 0.
  assign expire        = (TIMEOUT_CYCLES != 0) && in_rx_state && (timer == TMR_W'(1));
  assign crc_ok        = (crc == rx_crc);
  assign id_ok         = !id_check_en || (shadow[7:0] == expected_id);
  assign check_good    = (state == CHECK) && crc_ok && id_ok;
  assign check_crc_bad = (state == CHECK) && !crc_ok;
  assign check_id_bad  = (state == CHECK) && crc_ok && !id_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HUNT;
      hist            <= '0;
      idx             <= '0;
      crc             <= '0;
      rx_crc          <= '0;
      shadow          <= '0;
      timer           <= '0;
      frame_valid     <= 1'b0;
      crc_error       <= 1'b0;
      id_error        <= 1'b0;
      timeout_error   <= 1'b0;
      frame_id        <= '0;
      frame_payload   <= '0;
      good_count      <= '0;
      crc_error_count <= '0;
      timeout_count   <= '0;
    end else begin
      frame_valid   <= check_good;
      crc_error     <= check_crc_bad;
      id_error      <= check_id_bad;
      timeout_error <= expire;

      if (timer != '0) timer <= timer - 1'b1;

      case (state)
        HUNT: begin
          if (rx_valid) begin
            hist <= hist_next;
            if (magic_hit) begin
              state <= PAYLOAD;
              idx   <= '0;
              crc   <= 16'hFFFF;
              timer <= TMR_LOAD;
            end
          end
        end
        PAYLOAD: begin
          if (expire) begin
            state <= HUNT;
            hist  <= '0;
          end else if (rx_valid) begin
            shadow[8*idx +: 8] <= rx_data;
            crc                <= crc16_d8(crc, rx_data);
            timer              <= TMR_LOAD;
            if (idx == LAST_IDX) state <= CRC_HI;
            else                 idx   <= idx + 1'b1;
          end
        end
        CRC_HI: begin
          if (expire) begin
            state <= HUNT;
            hist  <= '0;
          end else if (rx_valid) begin
            rx_crc[15:8] <= rx_data;
            timer        <= TMR_LOAD;
            state        <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (expire) begin
            state <= HUNT;
            hist  <= '0;
          end else if (rx_valid) begin
            rx_crc[7:0] <= rx_data;
            timer       <= TMR_LOAD;
            state       <= CHECK;
          end
        end
        CHECK: begin
          state <= HUNT;
          hist  <= '0;
          if (check_good) begin
            frame_payload <= shadow;
            frame_id      <= shadow[7:0];
          end
        end
        default: state <= HUNT;
      endcase

      if (clear_counters) begin
        good_count      <= '0;
        crc_error_count <= '0;
        timeout_count   <= '0;
      end else begin
        good_count      <= bump(good_count, check_good);
        crc_error_count <= bump(crc_error_count, check_crc_bad);
        timeout_count   <= bump(timeout_count, expire);
      end
    end
  end

endmodule

// File: tb/tb_status_frame_receiver.sv
// Bench for status_frame_receiver: byte-queue reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized frame mix.
module tb_status_frame_receiver;

  localparam logic [31:0] MAGIC = 32'h1CEB00DA;
  localparam int ML  = 4;
  localparam int PL  = 22;
  localparam int TO  = 50;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic [7:0]      expected_id;
  logic            id_check_en;
  logic            clear_counters;
  logic            busy;
  logic            frame_valid;
  logic [7:0]      frame_id;
  logic [8*PL-1:0] frame_payload;
  logic            crc_error;
  logic            id_error;
  logic            timeout_error;
  logic [CW-1:0]   good_count;
  logic [CW-1:0]   crc_error_count;
  logic [CW-1:0]   timeout_count;

  status_frame_receiver #(
    .MAGIC(MAGIC), .MAGIC_LEN(ML), .PAYLOAD_LEN(PL), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .expected_id(expected_id), .id_check_en(id_check_en), .clear_counters(clear_counters),
    .busy(busy), .frame_valid(frame_valid), .frame_id(frame_id), .frame_payload(frame_payload),
    .crc_error(crc_error), .id_error(id_error), .timeout_error(timeout_error),
    .good_count(good_count), .crc_error_count(crc_error_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Byte-wise MSB-first polynomial division, poly 0x8005, init 0xFFFF.
  function automatic logic [15:0] crc_model(input logic [7:0] q[$], input int n);
    int c;
    c = 'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ (int'(q[i]) << 8);
      for (int k = 0; k < 8; k++)
        c = (c & 'h8000) != 0 ? (((c << 1) ^ 'h8005) & 'hFFFF) : ((c << 1) & 'hFFFF);
    end
    return c[15:0];
  endfunction

  function automatic logic [7:0] magic_byte(input int i);
    logic [31:0] m;
    m = MAGIC;
    return m[8*(ML-1-i) +: 8];
  endfunction

  // ---------------- reference model ----------------
  logic            m_busy, m_fv, m_crce, m_ide, m_toe;
  logic [7:0]      m_fid;
  logic [8*PL-1:0] m_payload;
  int              m_good, m_crcc, m_toc;
  logic [7:0]      hist [ML];
  logic [7:0]      fq [$];
  bit              in_frame, check_pend, hit, ev_good, ev_crc, ev_to;
  int              since;
  logic [15:0]     rc;

  initial begin
    forever begin
      @(posedge clk);
      m_fv = 0; m_crce = 0; m_ide = 0; m_toe = 0;
      if (reset) begin
        m_fid = '0; m_payload = '0; m_good = 0; m_crcc = 0; m_toc = 0;
        foreach (hist[i]) hist[i] = '0;
        fq.delete(); in_frame = 0; check_pend = 0; since = 0;
      end else begin
        ev_good = 0; ev_crc = 0; ev_to = 0;
        if (check_pend) begin
          rc = {fq[PL], fq[PL+1]};
          if (crc_model(fq, PL) != rc) begin m_crce = 1; ev_crc = 1; end
          else if (id_check_en && fq[0] != expected_id) m_ide = 1;
          else begin
            m_fv = 1; ev_good = 1; m_fid = fq[0];
            for (int i = 0; i < PL; i++) m_payload[8*i +: 8] = fq[i];
          end
          check_pend = 0; fq.delete();
          foreach (hist[i]) hist[i] = '0;
        end else if (in_frame) begin
          since++;
          if (TO != 0 && since == TO) begin
            m_toe = 1; ev_to = 1; in_frame = 0; fq.delete();
            foreach (hist[i]) hist[i] = '0;
          end else if (rx_valid) begin
            fq.push_back(rx_data); since = 0;
            if (fq.size() == PL + 2) begin in_frame = 0; check_pend = 1; end
          end
        end else if (rx_valid) begin
          for (int i = 0; i < ML - 1; i++) hist[i] = hist[i+1];
          hist[ML-1] = rx_data;
          hit = 1;
          for (int i = 0; i < ML; i++) if (hist[i] != magic_byte(i)) hit = 0;
          if (hit) begin in_frame = 1; since = 0; fq.delete(); end
        end
        if (clear_counters) begin
          m_good = 0; m_crcc = 0; m_toc = 0;
        end else begin
          if (ev_good && m_good < SAT) m_good++;
          if (ev_crc && m_crcc < SAT) m_crcc++;
          if (ev_to && m_toc < SAT) m_toc++;
        end
      end
      m_busy = in_frame || check_pend;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("busy", 256'(busy), 256'(m_busy));
        check("frame_valid", 256'(frame_valid), 256'(m_fv));
        check("frame_id", 256'(frame_id), 256'(m_fid));
        check("frame_payload", 256'(frame_payload), 256'(m_payload));
        check("crc_error", 256'(crc_error), 256'(m_crce));
        check("id_error", 256'(id_error), 256'(m_ide));
        check("timeout_error", 256'(timeout_error), 256'(m_toe));
        check("good_count", 256'(good_count), 256'(m_good));
        check("crc_error_count", 256'(crc_error_count), 256'(m_crcc));
        check("timeout_count", 256'(timeout_count), 256'(m_toc));
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic make_pl(input logic [7:0] id, input bit rnd, output logic [7:0] q[$]);
    q.delete();
    q.push_back(id);
    for (int k = 1; k < PL; k++) q.push_back(rnd ? 8'($urandom) : 8'(k));
  endtask

  // Sends magic+payload+CRC; optional long idle gap after byte long_pos.
  task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] lo_xor, input int gmax,
                            input int long_pos, input int long_gap);
    logic [15:0] c;
    logic [7:0]  all[$];
    int          g;
    c = crc_model(pl, PL);
    for (int i = 0; i < ML; i++) all.push_back(magic_byte(i));
    foreach (pl[i]) all.push_back(pl[i]);
    all.push_back(c[15:8]);
    all.push_back(c[7:0] ^ lo_xor);
    foreach (all[i]) begin
      g = (i == all.size() - 1) ? 0 : $urandom_range(gmax, 0);
      if (i == long_pos) g = long_gap;
      send_byte(all[i], g);
    end
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < ML; i++) send_byte(magic_byte(i), 1);
    for (int i = 0; i < n; i++) send_byte(8'(i + 1), (i == n - 1) ? 0 : 1);
  endtask

  logic [7:0] p[$];
  logic [7:0] s[$];
  logic [7:0] noise[$];
  int kind;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
    expected_id = 8'h05; id_check_en = 1'b1; clear_counters = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checking = 1'b1;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_good_count", 256'(good_count), 256'(0));
    check("rst_payload", 256'(frame_payload), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) s.push_back(8'(8'h31 + i));
    check("crc_model_123456789", 256'(crc_model(s, 9)), 256'(16'hAEE7));

    // Clean frame
    make_pl(8'h05, 0, p);
    send_frame(p, 8'h00, 1, -1, 0);
    check("clean_no_early_fv", 256'(frame_valid), 256'(0));
    @(negedge clk);
    check("clean_fv_latency", 256'(frame_valid), 256'(1));
    @(negedge clk);
    check("clean_fv_one_cycle", 256'(frame_valid), 256'(0));
    check("clean_frame_id", 256'(frame_id), 256'(8'h05));
    check("clean_payload_b1", 256'(frame_payload[15:8]), 256'(8'h01));
    check("clean_good_count", 256'(good_count), 256'(1));

    // Corrupt CRC low byte
    send_frame(p, 8'h01, 1, -1, 0);
    @(negedge clk);
    check("badcrc_pulse", 256'(crc_error), 256'(1));
    check("badcrc_no_fv", 256'(frame_valid), 256'(0));
    @(negedge clk);
    check("badcrc_count", 256'(crc_error_count), 256'(1));
    check("badcrc_payload_kept", 256'(frame_payload[15:8]), 256'(8'h01));

    // Id mismatch, then id check disabled
    make_pl(8'h07, 0, p);
    send_frame(p, 8'h00, 1, -1, 0);
    @(negedge clk);
    check("id_err_pulse", 256'(id_error), 256'(1));
    @(negedge clk);
    check("id_err_good_same", 256'(good_count), 256'(1));
    check("id_err_crc_same", 256'(crc_error_count), 256'(1));
    id_check_en = 1'b0;
    send_frame(p, 8'h00, 1, -1, 0);
    @(negedge clk);
    check("id_off_fv", 256'(frame_valid), 256'(1));
    check("id_off_frame_id", 256'(frame_id), 256'(8'h07));
    id_check_en = 1'b1;

    // Timeout after 10 payload bytes
    send_partial(10);
    repeat (TO - 1) @(negedge clk);
    check("to_not_early", 256'(timeout_error), 256'(0));
    check("to_busy_before", 256'(busy), 256'(1));
    @(negedge clk);
    check("to_pulse", 256'(timeout_error), 256'(1));
    check("to_busy_after", 256'(busy), 256'(0));
    check("to_count", 256'(timeout_count), 256'(1));
    make_pl(8'h05, 0, p);
    send_frame(p, 8'h00, 1, -1, 0);
    @(negedge clk);
    check("after_to_fv", 256'(frame_valid), 256'(1));

    // Overlapping magic prefix
    send_byte(8'h1C, 1);
    send_frame(p, 8'h00, 1, -1, 0);
    @(negedge clk);
    check("resync_fv", 256'(frame_valid), 256'(1));

    // Reset mid-payload
    send_partial(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 256'(busy), 256'(0));
    repeat (TO + 10) @(negedge clk);
    check("midrst_counts", 256'({good_count, crc_error_count, timeout_count}), 256'(0));
    send_frame(p, 8'h00, 1, -1, 0);
    @(negedge clk);
    check("midrst_next_fv", 256'(frame_valid), 256'(1));

    // clear_counters coinciding with a good frame
    send_frame(p, 8'h00, 1, -1, 0);
    clear_counters = 1'b1;
    @(negedge clk);
    clear_counters = 1'b0;
    check("clr_fv", 256'(frame_valid), 256'(1));
    check("clr_good_count", 256'(good_count), 256'(0));

    // Saturation
    repeat (SAT + 2) begin
      send_frame(p, 8'h00, 1, -1, 0);
      repeat (2) @(negedge clk);
    end
    check("sat_good_count", 256'(good_count), 256'(SAT));

    // Randomized mix
    noise = '{8'h1C, 8'hEB, 8'h00, 8'hDA};
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(9, 0);
      expected_id = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h05;
      id_check_en = 1'($urandom_range(1, 0));
      make_pl(($urandom_range(1, 0) == 0) ? 8'h05 : 8'($urandom), 1, p);
      case (kind)
        0, 1, 2, 3: send_frame(p, 8'h00, 2, -1, 0);
        4: send_frame(p, 8'($urandom_range(255, 1)), 2, -1, 0);
        5: send_frame(p, 8'h00, 1, $urandom_range(ML + PL, 0), $urandom_range(TO + 3, TO - 3));
        6: for (int i = 0; i < 8; i++)
             send_byte(($urandom_range(4, 0) == 4) ? 8'($urandom) : noise[$urandom_range(3, 0)], 1);
        7: begin
          clear_counters = 1'b1;
          @(negedge clk);
          clear_counters = 1'b0;
          send_frame(p, 8'h00, 2, -1, 0);
        end
        8: begin
          send_partial($urandom_range(PL, 1));
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end
        default: begin
          send_frame(p, 8'h00, 0, -1, 0);
          send_byte(8'($urandom), 1);
        end
      endcase
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    repeat (TO + 10) @(negedge clk);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_frame_receiver.md
Name: status_frame_receiver

Overview:
- Parametrised successor to the hard-wired status-frame matcher inside the motor-bus comms block.
- Sits between the uart_rx byte output and per-motor status registers; one instance per frame type.
- Hunts a configurable magic number and collects a configurable-length payload (byte 0 = motor id).
- Checks CRC16 (x^16+x^15+x^2+1, init 0xFFFF, D[7] first) and the id. Only good frames are published, through a double buffer.
- New vs. the inline matcher: inter-byte timeout, magic resync, id filtering, saturating statistics counters, stable output buffer.

Parameters:
- MAGIC, 32'h1CEB00DA, magic number, first byte = MAGIC[8*MAGIC_LEN-1 -: 8]
- MAGIC_LEN, 4, magic length in bytes, 1..4
- PAYLOAD_LEN, 22, payload bytes incl. id byte (CRC excluded), 1..64
- TIMEOUT_CYCLES, 2000, max clk cycles between accepted bytes once magic is found; 0 disables the timeout
- CNT_W, 16, statistics counter width

Ports:
- clk, in, 1, system clock
- reset, in, 1, reset
- rx_valid, in, 1, one-cycle strobe, rx_data valid
- rx_data, in, 8, received byte
- expected_id, in, 8, id to accept
- id_check_en, in, 1, 1 = reject frames whose id differs from expected_id
- clear_counters, in, 1, synchronous clear of the statistics counters
- busy, out, 1, high in any state other than HUNT
- frame_valid, out, 1, one-cycle pulse: new good frame published
- frame_id, out, 8, id byte of last good frame
- frame_payload, out, 8*PAYLOAD_LEN, last good payload; byte k at [8k+7:8k]
- crc_error, out, 1, one-cycle pulse
- id_error, out, 1, one-cycle pulse
- timeout_error, out, 1, one-cycle pulse
- good_count, out, CNT_W, good frames
- crc_error_count, out, CNT_W, CRC failures
- timeout_count, out, CNT_W, timeouts

Behaviour:
- Reset (synchronous, active-high): one clock. Clears all outputs and counters to 0, magic shift register to 0, state to HUNT. Reset mid-frame discards the partial frame with no error pulse.
- States: HUNT, PAYLOAD, CRC_HI, CRC_LO, CHECK.
- HUNT:
  - On rx_valid, shift the byte into a MAGIC_LEN-byte register.
  - If {shift[MAGIC_LEN-2:0], rx_data} == MAGIC: enter PAYLOAD next cycle, byte index = 0, running CRC = 0xFFFF.
  - Overlapping prefixes resync naturally (e.g. 1C 1C EB 00 DA matches).
- PAYLOAD:
  - Each rx_valid stores the byte into shadow[idx] and updates the CRC.
  - After byte PAYLOAD_LEN-1, go to CRC_HI.
- CRC_HI / CRC_LO: the next two bytes are the received CRC, MSB first. After CRC_LO, go to CHECK.
- CHECK (one cycle; result visible the cycle after CHECK):
  - CRC mismatch: crc_error=1 and crc_error_count++.
  - CRC ok, id_check_en=1 and shadow[0]!=expected_id: id_error=1. The id does not count in any counter.
  - Otherwise: copy shadow to frame_payload/frame_id, frame_valid=1, good_count++.
  - CRC failure takes precedence over id failure.
  - Always return to HUNT with the shift register cleared.
- frame_payload/frame_id change only on a good frame. They are stable otherwise, including during the next frame's reception.
- Latency: the last CRC byte strobe in cycle N gives CHECK in N+1 and the pulse in N+2.
- Timeout: counter loads TIMEOUT_CYCLES on magic match and on every accepted byte outside HUNT, and decrements otherwise. Reaching 0 outside HUNT (and outside CHECK) gives timeout_error=1, timeout_count++, and a return to HUNT with the shift register cleared. An rx_valid in the same cycle as expiry is dropped.
- Bytes arriving during CHECK are ignored; the rx_valid rate is at most one per 2 clks in practice.
- Counters saturate at all-ones. When clear_counters coincides with an increment, clear wins.
- All pulses are exactly one cycle; at most one of frame_valid/crc_error/id_error/timeout_error fires per frame.

Test Plan:
- Clean frame: MAGIC 1C EB 00 DA, payload id=0x05 then bytes 0x01..0x15, golden CRC from the bench nextCRC16_D8 model, expected_id=5, check_en=1. Response: frame_valid 2 cycles after the last byte, frame_id=0x05, frame_payload[15:8]=0x01, good_count=1.
- Corrupt CRC low byte (XOR 0x01) on the same frame. Response: crc_error pulse, crc_error_count=1, frame_payload unchanged from the previous frame, no frame_valid.
- Valid CRC, id=0x07, expected_id=5. With check_en=1: id_error pulse, no counter change. With check_en=0: frame_valid, frame_id=0x07.
- TIMEOUT_CYCLES=50, stop after 10 payload bytes. Response: timeout_error exactly 50 cycles after the last byte, timeout_count=1, busy=0. A following clean frame is accepted.
- Stream 1C 1C EB 00 DA + clean frame. Response: resync, frame_valid. Reset asserted mid-payload: busy=0, no pulses, the next clean frame is accepted.
- Force good_count to 0xFFFF (CNT_W=16) and send a good frame: stays 0xFFFF. clear_counters asserted together with a good frame: good_count=0, frame_valid still pulses.
